// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: one-cold column strobe, synchronized row sampling,
// per-key frame debounce, and a lowest-index-first press/release event port.
module keypad_scanner #(
  parameter int NROW       = 4,
  parameter int NCOL       = 4,
  parameter int COL_PERIOD = 100000,
  parameter int SETTLE     = 100,
  parameter int DEBOUNCE   = 3,
  localparam int NKEY      = NROW * NCOL,
  localparam int KW        = $clog2(NKEY)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NROW-1:0] row,
  output logic [NCOL-1:0] col,
  output logic [NKEY-1:0] keys,
  output logic            ev_valid,
  output logic [KW-1:0]   ev_code,
  output logic            ev_press,
  input  logic            ev_ready,
  output logic            overflow,
  input  logic            clr_overflow
);

  localparam int CW  = $clog2(COL_PERIOD);
  localparam int CIW = $clog2(NCOL);
  localparam int DW  = 4;

  typedef enum logic [1:0] {
    DRIVE  = 2'd0,
    SAMPLE = 2'd1,
    NEXT   = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [CIW-1:0]  col_idx_reg, col_idx_next;
  logic            run_reg;
  logic [NCOL-1:0] col_reg;

  logic [NROW-1:0] sync1_reg, sync2_reg;
  logic [NKEY-1:0] raw_reg;
  logic [NKEY-1:0] keys_reg;
  logic [NKEY-1:0] tog;
  logic [NKEY-1:0] mask_reg, mask_kept, mask_next, accept_mask;
  logic            ev_valid_reg, ev_press_reg, overflow_reg;
  logic [KW-1:0]   ev_code_reg;
  logic            capture, frame_end, accept, ovf_set;
  logic            low_found;
  logic [KW-1:0]   low_code;

  // Two-flop synchronizer; idle rows read high so the reset value is all ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= '1;
      sync2_reg <= '1;
    end else begin
      sync1_reg <= row;
      sync2_reg <= sync1_reg;
    end
  end

  // Scan FSM state register. run_reg is low only for the first cycle after
  // reset, so column 0 is driven from the first edge after deassertion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= DRIVE;
      cnt_reg     <= '0;
      col_idx_reg <= '0;
      run_reg     <= 1'b0;
      col_reg     <= '1;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      col_idx_reg <= col_idx_next;
      run_reg     <= 1'b1;
      col_reg     <= ~(NCOL'(1) << col_idx_next);
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    col_idx_next = col_idx_reg;
    if (!run_reg) begin
      cnt_next     = '0;
      col_idx_next = '0;
    end else begin
      case (state_reg)
        NEXT: begin
          cnt_next     = '0;
          col_idx_next = (col_idx_reg == CIW'(NCOL - 1)) ? '0 : col_idx_reg + CIW'(1);
        end
        default: cnt_next = cnt_reg + CW'(1);
      endcase
    end
    // The column's last cycle takes precedence over the sample slot.
    if (cnt_next == CW'(COL_PERIOD - 1))
      state_next = NEXT;
    else if (cnt_next == CW'(SETTLE))
      state_next = SAMPLE;
    else
      state_next = DRIVE;
  end

  assign capture   = (state_reg == SAMPLE) ||
                     ((SETTLE == COL_PERIOD - 1) && (state_reg == NEXT));
  assign frame_end = (state_reg == NEXT) && (col_idx_reg == CIW'(NCOL - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      raw_reg <= '0;
    else if (capture)
      raw_reg[int'(col_idx_reg) * NROW +: NROW] <= ~sync2_reg;
  end

  // Per-key debounce: DEBOUNCE consecutive differing frames flip the key.
  for (genvar gi = 0; gi < NKEY; gi++) begin : g_key
    logic [DW-1:0] db_cnt_reg;
    logic          differ;

    assign differ  = raw_reg[gi] ^ keys_reg[gi];
    assign tog[gi] = frame_end && differ && (db_cnt_reg == DW'(DEBOUNCE - 1));

    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        db_cnt_reg <= '0;
      else if (frame_end) begin
        if (!differ || tog[gi])
          db_cnt_reg <= '0;
        else
          db_cnt_reg <= db_cnt_reg + DW'(1);
      end
    end
  end

  always_comb begin
    low_found = 1'b0;
    low_code  = '0;
    for (int i = NKEY - 1; i >= 0; i--) begin
      if (mask_reg[i]) begin
        low_found = 1'b1;
        low_code  = KW'(i);
      end
    end
  end

  // Accept clears first, then toggles XOR in; a pending bit hit again is lost.
  assign accept      = ev_valid_reg && ev_ready;
  assign accept_mask = accept ? (NKEY'(1) << ev_code_reg) : '0;
  assign mask_kept   = mask_reg & ~accept_mask;
  assign mask_next   = mask_kept ^ tog;
  assign ovf_set     = |(mask_kept & tog);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      keys_reg     <= '0;
      mask_reg     <= '0;
      ev_valid_reg <= 1'b0;
      ev_code_reg  <= '0;
      ev_press_reg <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      keys_reg <= keys_reg ^ tog;
      mask_reg <= mask_next;
      if (accept)
        ev_valid_reg <= 1'b0;
      else if (!ev_valid_reg && low_found) begin
        ev_valid_reg <= 1'b1;
        ev_code_reg  <= low_code;
        ev_press_reg <= keys_reg[low_code];
      end
      if (ovf_set)
        overflow_reg <= 1'b1;
      else if (clr_overflow)
        overflow_reg <= 1'b0;
    end
  end

  assign col      = col_reg;
  assign keys     = keys_reg;
  assign ev_valid = ev_valid_reg;
  assign ev_code  = ev_code_reg;
  assign ev_press = ev_press_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a 4x4 keypad model driving row from col.
module tb_keypad_scanner;

  localparam int NR = 4;
  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] row;
  logic [NC-1:0] col;
  logic [15:0]   keys;
  logic          ev_valid;
  logic [3:0]    ev_code;
  logic          ev_press;
  logic          ev_ready;
  logic          overflow;
  logic          clr_overflow;
  logic [15:0]   pressed;

  int tests = 0;
  int fails = 0;

  keypad_scanner #(
    .NROW(NR), .NCOL(NC), .COL_PERIOD(16), .SETTLE(4), .DEBOUNCE(2)
  ) dut (
    .clk(clk), .reset(reset), .row(row), .col(col), .keys(keys),
    .ev_valid(ev_valid), .ev_code(ev_code), .ev_press(ev_press),
    .ev_ready(ev_ready), .overflow(overflow), .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  // Pressed key k = c*NR + r pulls row r low while column c is driven low.
  always_comb begin
    row = '1;
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NR; r++)
        if (!col[c] && pressed[c*NR + r]) row[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic watch(input int n, output int seen);
    seen = 0;
    repeat (n) begin
      tick(1);
      if (ev_valid) seen++;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_col"}, 32'(col), 32'hF);
    check({tag, "_keys"}, 32'(keys), 32'h0);
    check({tag, "_evv"}, 32'(ev_valid), 32'h0);
    check({tag, "_code"}, 32'(ev_code), 32'h0);
    check({tag, "_press"}, 32'(ev_press), 32'h0);
    check({tag, "_ovf"}, 32'(overflow), 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int  seen;
    logic stable;
    reset = 1'b1; ev_ready = 1'b1; clr_overflow = 1'b0; pressed = '0;
    tick(3);
    check_reset_state("reset");
    @(negedge clk) reset = 1'b0;
    tick(1);                                   // frame 0, offset 0

    // Idle column rotation
    check("idle_col0", 32'(col), 32'hE);
    tick(16); check("idle_col1", 32'(col), 32'hD);
    tick(16); check("idle_col2", 32'(col), 32'hB);
    tick(16); check("idle_col3", 32'(col), 32'h7);
    tick(16); check("idle_wrap", 32'(col), 32'hE);   // frame 1, offset 0
    check("idle_keys", 32'(keys), 32'h0);
    check("idle_evv", 32'(ev_valid), 32'h0);

    // Key 9 press then release
    pressed = 16'h0200;
    tick(64); check("k9_one_frame", 32'(keys), 32'h0);
    tick(64); check("k9_keys", 32'(keys), 32'h0200);  // frame 3, offset 0
    check("k9_evv_pre", 32'(ev_valid), 32'h0);
    tick(1);
    check("k9_evv", 32'(ev_valid), 32'h1);
    check("k9_code", 32'(ev_code), 32'd9);
    check("k9_press", 32'(ev_press), 32'h1);
    tick(1); check("k9_accepted", 32'(ev_valid), 32'h0);
    pressed = 16'h0000;                               // frame 3, offset 2
    tick(126); check("k9_rel_keys", 32'(keys), 32'h0);
    tick(1);
    check("k9_rel_evv", 32'(ev_valid), 32'h1);
    check("k9_rel_code", 32'(ev_code), 32'd9);
    check("k9_rel_press", 32'(ev_press), 32'h0);
    tick(1); check("k9_rel_accepted", 32'(ev_valid), 32'h0);

    // One-frame glitch on key 0
    tick(62);                                         // frame 6, offset 0
    pressed = 16'h0001;
    tick(64);
    pressed = 16'h0000;
    watch(128, seen);                                 // frame 9, offset 0
    check("glitch_keys", 32'(keys), 32'h0);
    check("glitch_events", 32'(seen), 32'h0);

    // Keys 3 and 12 together, consumer stalled
    ev_ready = 1'b0;
    pressed = 16'h1008;
    tick(128); check("k3k12_keys", 32'(keys), 32'h1008);
    tick(1);
    check("k3_evv", 32'(ev_valid), 32'h1);
    check("k3_code", 32'(ev_code), 32'd3);
    check("k3_press", 32'(ev_press), 32'h1);
    stable = 1'b1;
    repeat (10) begin
      tick(1);
      if (!(ev_valid === 1'b1 && ev_code === 4'd3 && ev_press === 1'b1)) stable = 1'b0;
    end
    check("k3_stall_stable", 32'(stable), 32'h1);
    ev_ready = 1'b1;
    tick(1); check("k3_accepted", 32'(ev_valid), 32'h0);
    tick(1);
    check("k12_evv", 32'(ev_valid), 32'h1);
    check("k12_code", 32'(ev_code), 32'd12);
    check("k12_press", 32'(ev_press), 32'h1);
    tick(1); check("k12_accepted", 32'(ev_valid), 32'h0);
    pressed = 16'h0000;                               // frame 11, offset 14
    tick(242); check("k3k12_rel_keys", 32'(keys), 32'h0);   // frame 15, offset 0
    check("k3k12_rel_evv", 32'(ev_valid), 32'h0);

    // Key 5 press+release while key 0's event is stuck: key 5 is lost
    ev_ready = 1'b0;
    pressed = 16'h0021;
    tick(128);
    check("ovf_keys_press", 32'(keys), 32'h0021);
    check("ovf_pre", 32'(overflow), 32'h0);
    pressed = 16'h0001;
    tick(1);
    check("k0_code", 32'(ev_code), 32'd0);
    check("k0_evv", 32'(ev_valid), 32'h1);
    tick(127);                                        // frame 19, offset 0
    check("ovf_keys_rel", 32'(keys), 32'h0001);
    check("ovf_set", 32'(overflow), 32'h1);
    check("ovf_hold_code", 32'(ev_code), 32'd0);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    check("ovf_clear", 32'(overflow), 32'h0);
    ev_ready = 1'b1;
    tick(1); check("k0_accepted", 32'(ev_valid), 32'h0);
    watch(20, seen);
    check("k5_no_event", 32'(seen), 32'h0);
    check("ovf_stays_clear", 32'(overflow), 32'h0);

    // Reset mid-frame with key 0 still held
    tick(72);                                         // frame 20, offset 30
    reset = 1'b1;
    #1;
    check_reset_state("midreset");
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    tick(1);
    check("rst_col0", 32'(col), 32'hE);
    tick(128);
    check("rst_k0_keys", 32'(keys), 32'h0001);
    tick(1);
    check("rst_k0_evv", 32'(ev_valid), 32'h1);
    check("rst_k0_code", 32'(ev_code), 32'd0);
    check("rst_k0_press", 32'(ev_press), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter NROW, default 4, number of row inputs (2..8).
REQ-002 Parameter NCOL, default 4, number of column outputs (2..8).
REQ-003 Parameter COL_PERIOD, default 100000, clock cycles each column is driven.
REQ-004 Parameter SETTLE, default 100, cycles from column drive to row sample; SHALL satisfy 3 <= SETTLE < COL_PERIOD.
REQ-005 Parameter DEBOUNCE, default 3, consecutive identical frames needed to change a key's debounced state (1..15).
REQ-006 Derived NKEY = NROW*NCOL; KW = clog2(NKEY); key index k = c*NROW + r.
REQ-007 clk  input  1  system clock, rising edge.
REQ-008 reset  input  1  asynchronous, active-high.
REQ-009 row  input  NROW  active-low row sense, asynchronous to clk.
REQ-010 col  output  NCOL  active-low one-cold column drive.
REQ-011 keys  output  NKEY  debounced pressed bitmap, bit k = 1 when key k is pressed.
REQ-012 ev_valid  output  1  key event available.
REQ-013 ev_code  output  KW  key index of the event.
REQ-014 ev_press  output  1  1 = press, 0 = release.
REQ-015 ev_ready  input  1  consumer accepts event.
REQ-016 overflow  output  1  sticky: an event was lost.
REQ-017 clr_overflow  input  1  synchronous clear of overflow.

Function
REQ-018 row SHALL pass through a 2-flop synchronizer before any use.
REQ-019 Scan FSM states DRIVE, SAMPLE, NEXT; column c is driven low for exactly COL_PERIOD cycles starting at offset c*COL_PERIOD within a frame of NCOL*COL_PERIOD cycles.
REQ-020 At offset SETTLE within column c, synchronized ~row SHALL be captured into raw bits c*NROW .. c*NROW+NROW-1.
REQ-021 After column NCOL-1, the scan SHALL wrap to column 0 with no idle cycle.
REQ-022 On the last frame cycle, per key: if raw equals keys, reset that key's counter; else increment it, and on reaching DEBOUNCE toggle keys bit k and clear the counter.
REQ-023 Each keys toggle SHALL XOR bit k into a pending-change mask; if bit k was already 1, it becomes 0 (net no change) and overflow SHALL set.
REQ-024 When ev_valid is 0 and the mask is nonzero, the lowest set index SHALL be loaded into ev_code, keys[ev_code] into ev_press, and ev_valid SHALL assert on the next edge.
REQ-025 ev_valid, ev_code, ev_press SHALL hold stable until a cycle with ev_valid && ev_ready; on that edge the mask bit for ev_code clears and ev_valid drops.
REQ-026 The next event MAY assert in the cycle after acceptance (one bubble minimum).
REQ-027 Accept and a new toggle of the same key in one cycle: clear then XOR, so the mask bit ends 1, no overflow.
REQ-028 Multiple toggles in one frame SHALL be reported in ascending key index.
REQ-029 clr_overflow SHALL clear overflow unless a new overflow occurs in the same cycle (set wins).
REQ-030 Multiple simultaneous presses in one column SHALL all be registered; no ghost-key suppression.

Reset
REQ-031 While reset: col = all ones, keys = 0, raw = 0, counters = 0, mask = 0, ev_valid = 0, ev_code = 0, ev_press = 0, overflow = 0, synchronizer = all ones.
REQ-032 Reset mid-frame SHALL abort the scan; column 0 SHALL be driven from the first clk edge after deassertion.

Verification (NROW=NCOL=4, COL_PERIOD=16, SETTLE=4, DEBOUNCE=2, frame=64 cycles)
REQ-033 Idle after reset: col cycles 1110,1101,1011,0111 every 16 cycles; keys = 0; ev_valid = 0.
REQ-034 Hold row[1]=0 only while col[2]=0, ev_ready=1: after 2 frames keys = 0x0200, one event code 9 press; release gives code 9 release after 2 more frames.
REQ-035 Glitch: row[0]=0 for a single frame only: keys stays 0, no event.
REQ-036 Keys 3 and 12 pressed in the same frame, ev_ready=0 for 10 cycles then 1: events code 3 then code 12, values stable while stalled.
REQ-037 ev_ready=0; key 5 pressed then released (each stable 2 frames): no event for key 5, overflow = 1; clr_overflow pulse sets overflow = 0.
REQ-038 Assert reset at frame offset 30 with key 0 held: all outputs at reset values; after deassertion, key 0 event is reported after 2 frames.
